// File: rtl/pong_pkg.sv
// Shared Pong types and constants: game-controller states, ball-block state/winner codes,
// and the screen geometry already used by the ball and paddle blocks.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_POINT = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   localparam logic [1:0] STATE_GM_IDLE  = 2'b00;
   localparam logic [1:0] STATE_GM_PLAY  = 2'b01;
   localparam logic [1:0] STATE_GM_POINT = 2'b00;
   localparam logic [1:0] STATE_GM_PAUSE = 2'b10;
   localparam logic [1:0] STATE_GM_OVER  = 2'b11;

   localparam logic [1:0] WINNER_NONE = 2'b00;
   localparam logic [1:0] WINNER_P1   = 2'b01;
   localparam logic [1:0] WINNER_P2   = 2'b10;

   localparam int unsigned SCREEN_W  = 640;
   localparam int unsigned SCREEN_H  = 480;
   localparam int unsigned PADDLE_W  = 8;
   localparam int unsigned PADDLE_H  = 64;
   localparam int unsigned BALL_SIZE = 8;

   // IDLE and POINT share 00: the ball block just holds the ball for a serve in both.
   function automatic logic [1:0] state_to_gm(input state_e s);
      case (s)
         ST_PLAY:  return STATE_GM_PLAY;
         ST_PAUSE: return STATE_GM_PAUSE;
         ST_OVER:  return STATE_GM_OVER;
         ST_POINT: return STATE_GM_POINT;
         default:  return STATE_GM_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/pong_game_ctrl_btn_edge.sv
// Button conditioner: 2-flop synchroniser followed by a registered rising-edge detector.
// A press yields a one-clk pulse on the 3rd clock edge after the raw input rises.
module btn_edge
   import pong_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic press
);

   logic [1:0] sync_q, sync_d;
   logic       dly_q, dly_d;
   logic       pulse_q, pulse_d;

   // NOTE: every _d is assigned on every path through always_comb, so no latch is inferred.
   always_comb begin
      sync_d  = {sync_q[0], btn_in};
      dly_d   = sync_q[1];
      pulse_d = sync_q[1] & ~dly_q;
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         dly_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         dly_q   <= dly_d;
         pulse_q <= pulse_d;
      end
   end

   assign press = pulse_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: sequences the ball block via state_gm / ball_rst_n and detects points.
// Optional serve delay (auto-resume from POINT after SERVE_DELAY_MS ticks): define SERVE_DELAY_EN.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned WIN_SCORE      = 7,
   parameter int unsigned SERVE_DELAY_MS = 1000,
   parameter int unsigned CNT_W          = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1ms,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic [3:0] p1_scr,
   input  logic [3:0] p2_scr,
   output logic [1:0] state_gm,
   output logic       ball_rst_n,
   output logic [1:0] winner,
   output logic       point_pulse
);

   if (WIN_SCORE < 1 || WIN_SCORE > 15 || CNT_W < 1 || CNT_W > 30 ||
       SERVE_DELAY_MS < 1 || SERVE_DELAY_MS > (1 << CNT_W)) begin : g_param_err
      $error("pong_game_ctrl: parameter out of range");
   end

   logic start_pulse, pause_pulse;

   btn_edge u_start (.clk(clk), .reset(reset), .btn_in(btn_start), .press(start_pulse));
   btn_edge u_pause (.clk(clk), .reset(reset), .btn_in(btn_pause), .press(pause_pulse));

   state_e     state_q, state_d;
   logic [1:0] state_gm_q, state_gm_d;
   logic [1:0] winner_q, winner_d;
   logic       ball_rst_n_q, ball_rst_n_d;
   logic       point_pulse_q, point_pulse_d;
   logic [3:0] prev_p1_q, prev_p1_d;
   logic [3:0] prev_p2_q, prev_p2_d;
   logic       p1_hit, p2_hit, p1_win, p2_win;

`ifdef SERVE_DELAY_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY_MS - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      p1_hit = (p1_scr != prev_p1_q);
      p2_hit = (p2_scr != prev_p2_q);
      p1_win = p1_hit && (32'(p1_scr) >= WIN_SCORE);
      p2_win = p2_hit && (32'(p2_scr) >= WIN_SCORE);

      state_d       = state_q;
      winner_d      = winner_q;
      point_pulse_d = 1'b0;
      prev_p1_d     = p1_scr;
      prev_p2_d     = p2_scr;
      // A pending ball reset is released only after the ball block has seen it on a tick.
      ball_rst_n_d  = ball_rst_n_q | tick_1ms;

      case (state_q)
         ST_IDLE: begin
            if (start_pulse && ball_rst_n_q) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (p1_hit || p2_hit) begin
               point_pulse_d = 1'b1;
               if (p1_win) begin
                  state_d  = ST_OVER;
                  winner_d = WINNER_P1;
               end else if (p2_win) begin
                  state_d  = ST_OVER;
                  winner_d = WINNER_P2;
               end else begin
                  state_d = ST_POINT;
               end
            end else if (pause_pulse) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (pause_pulse) state_d = ST_PLAY;
         end
         ST_POINT: begin
`ifdef SERVE_DELAY_EN
            if (tick_1ms && cnt_q == CNT_LAST) state_d = ST_PLAY;
`else
            if (start_pulse) state_d = ST_PLAY;
`endif
         end
         ST_OVER: begin
            if (start_pulse) begin
               state_d      = ST_IDLE;
               winner_d     = WINNER_NONE;
               ball_rst_n_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      state_gm_d = state_to_gm(state_d);

`ifdef SERVE_DELAY_EN
      cnt_d = cnt_q;
      if (state_d == ST_POINT && state_q != ST_POINT) cnt_d = '0;
      else if (state_q == ST_POINT && tick_1ms)      cnt_d = cnt_q + CNT_W'(1);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         state_gm_q    <= STATE_GM_IDLE;
         winner_q      <= WINNER_NONE;
         ball_rst_n_q  <= 1'b0;
         point_pulse_q <= 1'b0;
         prev_p1_q     <= '0;
         prev_p2_q     <= '0;
`ifdef SERVE_DELAY_EN
         cnt_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         state_gm_q    <= state_gm_d;
         winner_q      <= winner_d;
         ball_rst_n_q  <= ball_rst_n_d;
         point_pulse_q <= point_pulse_d;
         prev_p1_q     <= prev_p1_d;
         prev_p2_q     <= prev_p2_d;
`ifdef SERVE_DELAY_EN
         cnt_q         <= cnt_d;
`endif
      end
   end

   assign state_gm    = state_gm_q;
   assign ball_rst_n  = ball_rst_n_q;
   assign winner      = winner_q;
   assign point_pulse = point_pulse_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus pushes {cycle, expected outputs} entries,
// an independent monitor compares them at the falling edge of the stated cycle.
module tb_pong_game_ctrl;

   logic       clk;
   logic       reset;
   logic       tick_1ms;
   logic       btn_start;
   logic       btn_pause;
   logic [3:0] p1_scr;
   logic [3:0] p2_scr;
   logic [1:0] state_gm;
   logic       ball_rst_n;
   logic [1:0] winner;
   logic       point_pulse;

`ifdef SERVE_DELAY_EN
   localparam int unsigned SDM = 3;
`else
   localparam int unsigned SDM = 1000;
`endif

   pong_game_ctrl #(.WIN_SCORE(7), .SERVE_DELAY_MS(SDM), .CNT_W(10)) dut (
      .clk(clk), .reset(reset), .tick_1ms(tick_1ms),
      .btn_start(btn_start), .btn_pause(btn_pause),
      .p1_scr(p1_scr), .p2_scr(p2_scr),
      .state_gm(state_gm), .ball_rst_n(ball_rst_n),
      .winner(winner), .point_pulse(point_pulse)
   );

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [5:0]  val;   // {state_gm, ball_rst_n, winner, point_pulse}
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   bit          tick_en = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [5:0] act, input logic [5:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got gm=%b rst_n=%b win=%b pp=%b, expected gm=%b rst_n=%b win=%b pp=%b",
                  nm, cyc, act[5:4], act[3], act[2:1], act[0], want[5:4], want[3], want[2:1], want[0]);
      end
   endtask

   // Monitor: compares every expectation due at this cycle against the registered outputs.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
               if (sb[i].cyc == cyc) begin
                  check(sb[i].name, {state_gm, ball_rst_n, winner, point_pulse}, sb[i].val);
               end else begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL %s: due at cycle %0d but not sampled (now %0d)", sb[i].name, sb[i].cyc, cyc);
               end
               sb.delete(i);
            end
         end
      end
   end

   task automatic exp_push(input int unsigned at, input string nm, input logic [1:0] gm,
                           input logic rn, input logic [1:0] w, input logic pp);
      exp_t e;
      e.cyc  = at;
      e.name = nm;
      e.val  = {gm, rn, w, pp};
      sb.push_back(e);
   endtask

   // Tick pulses are sampled on every posedge whose number is a multiple of 8.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick_1ms = tick_en && (((cyc + 1) % 8) == 0);
      end
   endtask

   function automatic int unsigned next_tick(input int unsigned c);
      return ((c / 8) + 1) * 8;
   endfunction

   task automatic press(input bit is_start);
      if (is_start) btn_start = 1'b1;
      else          btn_pause = 1'b1;
      step(3);
      btn_start = 1'b0;
      btn_pause = 1'b0;
   endtask

   // Press, expecting state_gm to show gm exactly 4 clk after the rise, winner none.
   task automatic press_expect(input bit is_start, input string nm, input logic [1:0] gm);
      exp_push(cyc + 4, nm, gm, 1'b1, 2'b00, 1'b0);
      press(is_start);
      step(1);
   endtask

   task automatic score_point(input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] gm,
                              input logic [1:0] w, input string nm);
      p1_scr = s1;
      p2_scr = s2;
      exp_push(cyc + 1, nm, gm, 1'b1, w, 1'b1);
      exp_push(cyc + 2, {nm, "_once"}, gm, 1'b1, w, 1'b0);
      step(2);
   endtask

   task automatic resume_point(input int unsigned entry);
`ifdef SERVE_DELAY_EN
      int unsigned t3;
      t3 = next_tick(entry) + 16;
      exp_push(t3 - 1, "serve_wait", 2'b00, 1'b1, 2'b00, 1'b0);
      exp_push(t3, "serve_resume", 2'b01, 1'b1, 2'b00, 1'b0);
      press(1'b1);
      while (cyc < t3) step(1);
`else
      exp_push(cyc + 3, "point_hold", 2'b00, 1'b1, 2'b00, 1'b0);
      press_expect(1'b1, "point_resume", 2'b01);
`endif
   endtask

   // From OVER: start press requests a ball reset; a press during the pending reset is held off.
   task automatic restart_game();
      int unsigned y;
      while ((cyc % 8) != 5) step(1);
      y = cyc;
      exp_push(y + 4, "restart_idle", 2'b00, 1'b0, 2'b00, 1'b0);
      press(1'b1);
      step(1);
      p1_scr = 4'd0;
      p2_scr = 4'd0;
      exp_push(y + 10, "holdoff", 2'b00, 1'b0, 2'b00, 1'b0);
      exp_push(y + 11, "ball_release", 2'b00, 1'b1, 2'b00, 1'b0);
      press(1'b1);
      step(5);
      press_expect(1'b1, "replay", 2'b01);
   endtask

   initial begin
      int unsigned entry, t_rel;
      reset     = 1'b1;
      tick_1ms  = 1'b0;
      btn_start = 1'b0;
      btn_pause = 1'b0;
      p1_scr    = 4'd0;
      p2_scr    = 4'd0;

      // Reset values, ball reset released by the first tick, start into PLAY.
      exp_push(2, "reset_vals", 2'b00, 1'b0, 2'b00, 1'b0);
      step(2);
      reset   = 1'b0;
      tick_en = 1'b1;
      exp_push(7, "ball_rst_hold", 2'b00, 1'b0, 2'b00, 1'b0);
      exp_push(8, "ball_rst_rise", 2'b00, 1'b1, 2'b00, 1'b0);
      step(6);
      exp_push(cyc + 3, "start_lat3", 2'b00, 1'b1, 2'b00, 1'b0);
      press_expect(1'b1, "start_play", 2'b01);

      // Point by player 1, pause ignored in POINT, then resume.
      score_point(4'd1, 4'd0, 2'b00, 2'b00, "p1_point");
      entry = cyc - 1;
      press_expect(1'b0, "point_ign_pause", 2'b00);
      resume_point(entry);

      // Pause; score change and start press ignored while paused; unpause.
      press_expect(1'b0, "pause", 2'b10);
      p2_scr = 4'd1;
      exp_push(cyc + 6, "pause_hold", 2'b10, 1'b1, 2'b00, 1'b0);
      press(1'b1);
      step(3);
      exp_push(cyc + 5, "no_late_point", 2'b01, 1'b1, 2'b00, 1'b0);
      press_expect(1'b0, "unpause", 2'b01);
      step(1);

      // Player-2 point, player 1 at WIN_SCORE-1 is still a plain point, then player 1 wins.
      score_point(4'd1, 4'd2, 2'b00, 2'b00, "p2_point");
      resume_point(cyc - 1);
      score_point(4'd6, 4'd2, 2'b00, 2'b00, "p1_six");
      resume_point(cyc - 1);
      score_point(4'd7, 4'd2, 2'b11, 2'b01, "p1_win");
      restart_game();

      // Both players reach 7 on the same clk: player 1 has priority.
      press_expect(1'b0, "pause2", 2'b10);
      p1_scr = 4'd6;
      p2_scr = 4'd6;
      step(2);
      press_expect(1'b0, "unpause2", 2'b01);
      score_point(4'd7, 4'd7, 2'b11, 2'b01, "tie_p1_prio");
      restart_game();

      // Player 2 wins alone.
      press_expect(1'b0, "pause3", 2'b10);
      p2_scr = 4'd6;
      step(2);
      press_expect(1'b0, "unpause3", 2'b01);
      score_point(4'd0, 4'd7, 2'b11, 2'b10, "p2_win");
      restart_game();

      // Reset while paused after a serve-delay run; everything returns to reset values.
      score_point(4'd1, 4'd0, 2'b00, 2'b00, "pre_rst_point");
      resume_point(cyc - 1);
      press_expect(1'b0, "pause4", 2'b10);
      reset = 1'b1;
      exp_push(cyc + 1, "reset_mid", 2'b00, 1'b0, 2'b00, 1'b0);
      step(1);
      reset = 1'b0;
      t_rel = next_tick(cyc);
      exp_push(t_rel, "reset_ball_rel", 2'b00, 1'b1, 2'b00, 1'b0);
      while (cyc < t_rel) step(1);
      press_expect(1'b1, "post_reset_play", 2'b01);

      step(3);
      #1;
      while (sb.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: due at cycle %0d never reached", sb[0].name, sb[0].cyc);
         void'(sb.pop_front());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
